// File: rtl/rv32v_mem_lane_sequencer_if.sv
// Data-memory bus between the vector memory-stage sequencer and the
// single-ported data memory.
//   master (sequencer): drives dmem_ren/dmem_wen strobes, word address,
//                       lane-shifted store data and byte enables; samples
//                       dmem_busy and dmem_load.
//   slave  (memory)   : the mirror image.
// A transfer completes on the first cycle a strobe is high with dmem_busy low;
// dmem_load is valid on that cycle.
interface rv32v_mem_lane_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dmem_ren;
  logic              dmem_wen;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_store;
  logic [3:0]        dmem_byte_en;
  logic              dmem_busy;
  logic [DATA_W-1:0] dmem_load;

  modport master (
    output dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_byte_en,
    input  dmem_busy, dmem_load
  );

  modport slave (
    input  dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_byte_en,
    output dmem_busy, dmem_load
  );
endinterface

// File: rtl/rv32v_mem_lane_sequencer.sv
// Vector memory-stage lane sequencer.
// Serializes the loads/stores of two vector lanes onto one data-memory port,
// lane 0 first, generating byte enables from the element width, aligning store
// and load data, and stalling the pipeline until all enabled lanes finish.
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   load, store, wen[1:0]     memory-stage op and per-lane enables
//   eew[1:0]                  element width 0=8b 1=16b 2=32b (3 illegal)
//   aluresult0/1              lane byte addresses
//   storedata0/1              lane store elements (LSB-justified)
//   flush                     drop the current request
//   stall                     hold the execute->memory latch
//   done                      one-cycle completion pulse
//   loaddata0/1               zero-extended load elements (valid with done)
//   misaligned                sticky per request, valid with done
//   bus                       data-memory port (master side)
module rv32v_mem_lane_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load,
  input  logic              store,
  input  logic [1:0]        wen,
  input  logic [1:0]        eew,
  input  logic [31:0]       aluresult0,
  input  logic [31:0]       aluresult1,
  input  logic [DATA_W-1:0] storedata0,
  input  logic [DATA_W-1:0] storedata1,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] loaddata0,
  output logic [DATA_W-1:0] loaddata1,
  output logic              misaligned,
  rv32v_mem_lane_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, LANE0, LANE1, DONE} state_t;

  function automatic logic [3:0] be_f(logic [1:0] e, logic [1:0] off);
    case (e)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic mis_f(logic [1:0] e, logic [1:0] off);
    return (e == 2'd1 && off[0]) || (e == 2'd2 && off != 2'd0) || (e == 2'd3);
  endfunction

  function automatic logic [DATA_W-1:0] ext_f(logic [DATA_W-1:0] d,
                                               logic [1:0] e, logic [1:0] off);
    logic [DATA_W-1:0] s;
    s = d >> {off, 3'b000};
    case (e)
      2'd0:    return {{(DATA_W-8){1'b0}},  s[7:0]};
      2'd1:    return {{(DATA_W-16){1'b0}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  state_t state, state_nx;

  // captured request
  logic              store_q;
  logic [1:0]        wen_q;
  logic [1:0]        eew_q;
  logic [31:0]       addr0_q, addr1_q;
  logic [DATA_W-1:0] sd1_q;
  logic              flush_q;
  logic              mis_q;
  // load elements staged until the request retires, so a flushed request
  // never disturbs the visible loaddata outputs
  logic [DATA_W-1:0] ld0_q, ld1_q;

  logic              req, issue, strobe, adv, kill, rd_cpl;
  logic              src_store, src_mis;
  logic [1:0]        src_eew;
  logic [31:0]       src_addr, cur_addr;
  logic [DATA_W-1:0] src_sd, cpl_data;

  assign req    = (load | store) && (wen != 2'b00) && !flush;
  assign strobe = bus.dmem_ren | bus.dmem_wen;
  // a misaligned lane has no strobe and simply advances
  assign adv    = !strobe || !bus.dmem_busy;
  assign rd_cpl = bus.dmem_ren && !bus.dmem_busy;
  assign kill   = flush_q | flush;

  // Lane about to be issued: straight from the inputs on accept, otherwise
  // lane 1 from the captured copy.
  always_comb begin
    src_store = store_q;
    src_eew   = eew_q;
    src_addr  = addr1_q;
    src_sd    = sd1_q;
    if (state == IDLE) begin
      src_store = store;
      src_eew   = eew;
      src_addr  = wen[0] ? aluresult0 : aluresult1;
      src_sd    = wen[0] ? storedata0 : storedata1;
    end
  end

  assign src_mis  = mis_f(src_eew, src_addr[1:0]);
  assign cur_addr = (state == LANE1) ? addr1_q : addr0_q;
  assign cpl_data = ext_f(bus.dmem_load, eew_q, cur_addr[1:0]);

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_nx = wen[0] ? LANE0 : LANE1;
        issue    = 1'b1;
      end
      LANE0: if (adv) begin
        if (kill)          state_nx = IDLE;
        else if (wen_q[1]) begin
          state_nx = LANE1;
          issue    = 1'b1;
        end
        else               state_nx = DONE;
      end
      LANE1: if (adv) state_nx = kill ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign done  = (state == DONE);
  // gated by reset so the pipeline is released while reset is asserted
  assign stall = nRST && ((state == IDLE && req) || state == LANE0 || state == LANE1);
  assign misaligned = mis_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state            <= IDLE;
      store_q          <= 1'b0;
      wen_q            <= 2'b00;
      eew_q            <= 2'd0;
      addr0_q          <= '0;
      addr1_q          <= '0;
      sd1_q            <= '0;
      flush_q          <= 1'b0;
      mis_q            <= 1'b0;
      ld0_q            <= '0;
      ld1_q            <= '0;
      loaddata0        <= '0;
      loaddata1        <= '0;
      bus.dmem_ren     <= 1'b0;
      bus.dmem_wen     <= 1'b0;
      bus.dmem_addr    <= '0;
      bus.dmem_store   <= '0;
      bus.dmem_byte_en <= 4'b0000;
    end else begin
      state <= state_nx;

      if (state == IDLE && req) begin
        store_q <= store;
        wen_q   <= wen;
        eew_q   <= eew;
        addr0_q <= aluresult0;
        addr1_q <= aluresult1;
        sd1_q   <= storedata1;
        flush_q <= 1'b0;
        ld0_q   <= '0;
        ld1_q   <= '0;
        // load+store together is treated as a store and flagged
        mis_q   <= (load && store) || src_mis;
      end else if (issue) begin
        mis_q   <= mis_q | src_mis;
      end

      if ((state == LANE0 || state == LANE1) && flush)
        flush_q <= 1'b1;

      if (issue) begin
        bus.dmem_ren     <= !src_store && !src_mis;
        bus.dmem_wen     <=  src_store && !src_mis;
        bus.dmem_addr    <= {src_addr[ADDR_W-1:2], 2'b00};
        bus.dmem_byte_en <= be_f(src_eew, src_addr[1:0]);
        bus.dmem_store   <= src_sd << {src_addr[1:0], 3'b000};
      end else if (state_nx == IDLE || state_nx == DONE) begin
        bus.dmem_ren <= 1'b0;
        bus.dmem_wen <= 1'b0;
      end

      if (rd_cpl) begin
        if (state == LANE0) ld0_q <= cpl_data;
        else                ld1_q <= cpl_data;
      end

      // publish on retirement; the final lane's data bypasses its stage reg
      if (state_nx == DONE && state != DONE) begin
        loaddata0 <= (rd_cpl && state == LANE0) ? cpl_data : ld0_q;
        loaddata1 <= (rd_cpl && state == LANE1) ? cpl_data : ld1_q;
      end

      // the sticky flag lives until the request leaves DONE or is flushed
      if (state == DONE || ((state == LANE0 || state == LANE1) && state_nx == IDLE))
        mis_q <= 1'b0;
    end
  end

endmodule
